loop_event_checker: RTL

Receive-side checker for the single-counter, event-driven nested-loop stream (outer loop OUTER_N, inner loop INNER_N per outer).
- Consumes outer/inner event strobes plus the inner-loop action value.
- Reconstructs loop indices and verifies the event ordering, counts and action values.
- Reports done/err to the bench or system controller; sits downstream of the loop-sequence generator.

---
 rtl/loop_event_checker.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/loop_event_checker.sv
// rtl/loop_event_checker.sv - receive-side checker for the event-driven nested-loop stream
// Optional timeout watchdog (err_code 3) is built only when LOOP_CHK_TIMEOUT_EN is defined.
module loop_event_checker #(
    parameter int OUTER_N = 10,
    parameter int INNER_N = 10,
    parameter int TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       outer_evt,
    input  logic       inner_evt,
    input  logic [7:0] act_in,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] err_code,
    output logic [7:0] x_idx,
    output logic [7:0] y_idx,
    output logic [7:0] last_act
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_OUTER = 3'd1,
        S_WAIT_INNER = 3'd2,
        S_FIN        = 3'd3,
        S_FAIL       = 3'd4
    } state_t;

    localparam logic [7:0] OUTER_LAST = 8'(OUTER_N);
    localparam logic [7:0] INNER_LAST = 8'(INNER_N);

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_ORDER   = 3'd1;
    localparam logic [2:0] CODE_COUNT   = 3'd2;
    localparam logic [2:0] CODE_TIMEOUT = 3'd3;
    localparam logic [2:0] CODE_ACT     = 3'd4;

    state_t     r_state;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic [2:0] r_err_code;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [7:0] r_last;

    state_t     w_state_nxt;
    logic [2:0] w_fail_code;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_err_nxt;
    logic [2:0] w_err_code_nxt;
    logic [7:0] w_x_nxt;
    logic [7:0] w_y_nxt;
    logic [7:0] w_last_nxt;

    logic       w_any_evt;
    logic       w_outer_first;
    logic [7:0] w_x_cur;
    logic [7:0] w_y_base;
    logic [7:0] w_y_cur;
    logic       w_act_ok;
    logic       w_inner_done;
    logic       w_run_done;
    logic       w_to_hit;

    assign w_any_evt = outer_evt | inner_evt;

    // An outer event in WAIT_OUTER is applied before a coincident inner event.
    assign w_outer_first = (r_state == S_WAIT_OUTER) && outer_evt;
    assign w_x_cur       = w_outer_first ? (r_x + 8'd1) : r_x;
    assign w_y_base      = w_outer_first ? 8'd0 : r_y;
    assign w_y_cur       = w_y_base + 8'd1;
    assign w_act_ok      = (act_in == w_x_cur);
    assign w_inner_done  = (w_y_cur == INNER_LAST);
    assign w_run_done    = (w_x_cur == OUTER_LAST);

`ifdef LOOP_CHK_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_to_cnt;
    logic [15:0] w_to_nxt;

    // Fires on the edge where the idle count would reach TIMEOUT.
    assign w_to_hit = (r_to_cnt == TO_LAST) && !w_any_evt;
`else
    // Without the watchdog the checker waits forever; TIMEOUT has no effect.
    assign w_to_hit = 1'b0 & (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= CODE_NONE;
            r_x        <= 8'd0;
            r_y        <= 8'd0;
            r_last     <= 8'd0;
`ifdef LOOP_CHK_TIMEOUT_EN
            r_to_cnt   <= 16'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_last     <= w_last_nxt;
`ifdef LOOP_CHK_TIMEOUT_EN
            r_to_cnt   <= w_to_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fail_code = CODE_NONE;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_WAIT_OUTER;
                end
            end
            S_WAIT_OUTER: begin
                if (outer_evt) begin
                    if (!inner_evt) begin
                        w_state_nxt = S_WAIT_INNER;
                    end else if (!w_act_ok) begin
                        w_state_nxt = S_FAIL;
                        w_fail_code = CODE_ACT;
                    end else if (w_inner_done) begin
                        w_state_nxt = w_run_done ? S_FIN : S_WAIT_OUTER;
                    end else begin
                        w_state_nxt = S_WAIT_INNER;
                    end
                end else if (inner_evt) begin
                    w_state_nxt = S_FAIL;
                    w_fail_code = CODE_ORDER;
                end else if (w_to_hit) begin
                    w_state_nxt = S_FAIL;
                    w_fail_code = CODE_TIMEOUT;
                end
            end
            S_WAIT_INNER: begin
                if (outer_evt) begin
                    w_state_nxt = S_FAIL;
                    w_fail_code = CODE_COUNT;
                end else if (inner_evt) begin
                    if (!w_act_ok) begin
                        w_state_nxt = S_FAIL;
                        w_fail_code = CODE_ACT;
                    end else if (w_inner_done) begin
                        w_state_nxt = w_run_done ? S_FIN : S_WAIT_OUTER;
                    end
                end else if (w_to_hit) begin
                    w_state_nxt = S_FAIL;
                    w_fail_code = CODE_TIMEOUT;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            S_FAIL:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_err;
        w_err_code_nxt = r_err_code;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_last_nxt     = r_last;
`ifdef LOOP_CHK_TIMEOUT_EN
        w_to_nxt       = r_to_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_busy_nxt     = 1'b1;
                    w_err_nxt      = 1'b0;
                    w_err_code_nxt = CODE_NONE;
                    w_x_nxt        = 8'd0;
                    w_y_nxt        = 8'd0;
`ifdef LOOP_CHK_TIMEOUT_EN
                    w_to_nxt       = 16'd0;
`endif
                end
            end
            S_WAIT_OUTER, S_WAIT_INNER: begin
                // Indices freeze on error; only the first error of a run is recorded.
                if (w_state_nxt == S_FAIL) begin
                    w_busy_nxt     = 1'b0;
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = w_fail_code;
                end else begin
                    if (w_any_evt) begin
                        w_x_nxt = w_x_cur;
                        w_y_nxt = inner_evt ? w_y_cur : w_y_base;
                    end
                    if (inner_evt) begin
                        w_last_nxt = act_in;
                    end
                    if (w_state_nxt == S_FIN) begin
                        w_busy_nxt = 1'b0;
                        w_done_nxt = 1'b1;
                    end
`ifdef LOOP_CHK_TIMEOUT_EN
                    w_to_nxt = w_any_evt ? 16'd0 : (r_to_cnt + 16'd1);
`endif
                end
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign x_idx    = r_x;
    assign y_idx    = r_y;
    assign last_act = r_last;

endmodule
